sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO; next generation of the 16x8 FIFO.
//  Generic width/depth, programmable almost-full/almost-empty levels, occupancy count, data_valid strobe.
//  Sits between a producer and a consumer in the same clock domain (e.g. SPI slave <-> RAM path).
// PARAMETERS
//  FIFO_WIDTH  16             data word width, >=1
//  FIFO_DEPTH  8              number of entries, >=2; need not be a power of 2
//  AF_LEVEL    FIFO_DEPTH-1   almostfull asserts at count >= AF_LEVEL (and not full)
//  AE_LEVEL    1              almostempty asserts at count <= AE_LEVEL (and not empty)
//  CNT_W       $clog2(FIFO_DEPTH+1)  derived width of count; not overridden
// PORTS
//  clk          in   1           clock, all logic on rising edge
//  rst          in   1           asynchronous, active-high reset
//  wr_en        in   1           write request
//  data_in      in   FIFO_WIDTH  write data
//  rd_en        in   1           read request
//  data_out     out  FIFO_WIDTH  read data
//  data_valid   out  1           data_out carries a newly popped word
//  wr_ack       out  1           registered: previous-cycle write accepted
//  overflow     out  1           registered: previous-cycle write rejected (full)
//  underflow    out  1           registered: previous-cycle read rejected (empty)
//  full         out  1           count == FIFO_DEPTH (combinational from count)
//  empty        out  1           count == 0
//  almostfull   out  1           AF_LEVEL <= count < FIFO_DEPTH
//  almostempty  out  1           0 < count <= AE_LEVEL
//  count        out  CNT_W       current occupancy
// BEHAVIOUR
//  Reset (rst=1, any time, async):
//   - Pointers and count go to 0; data_out=0; data_valid, wr_ack, overflow, underflow all 0.
//   - Hence empty=1; full, almostfull, almostempty = 0. Storage contents are don't-care.
//   - An operation in flight on the reset cycle is discarded.
//  Acceptance, per cycle, evaluated against count at the clock edge:
//   - Write accepted iff wr_en && count<FIFO_DEPTH. Read accepted iff rd_en && count>0.
//   - Full with wr_en&rd_en: read accepted, write rejected -> overflow=1, count-1.
//   - Empty with wr_en&rd_en: write accepted, read rejected -> underflow=1, count+1.
//   - Otherwise, both accepted: count unchanged, both pointers advance.
//  Handshake outputs (registered, 1 cycle after the request):
//   - wr_ack=accepted write; overflow=wr_en&&!accepted.
//   - underflow=rd_en&&!accepted. All three are 0 when the request is low.
//  Pointers:
//   - wr_ptr/rd_ptr range 0..FIFO_DEPTH-1; wrap to 0 after FIFO_DEPTH-1. No power-of-2 assumption.
//   - count changes by +1, -1 or 0; it never exceeds FIFO_DEPTH and never goes below 0.
//  Read data, default mode:
//   - Accepted read -> data_out = mem[rd_ptr] on the next edge; latency 1; data_valid=1 for that cycle.
//   - Otherwise data_out holds its last value and data_valid=0.
//  Flags are combinational decodes of count, so they are valid the cycle count updates.
// CONFIGURATION
//  FIFO_FWFT_EN defined: first-word-fall-through.
//   - data_out = mem[rd_ptr] combinationally; data_valid = !empty.
//   - rd_en acts as a pop acknowledge: the next word appears the cycle after an accepted read.
//   - data_out is don't-care while empty; read latency 0. All other behaviour unchanged.
//  FIFO_FWFT_EN undefined: registered read mode as described above.
// TESTING (FIFO_WIDTH=16, FIFO_DEPTH=8, defaults; a queue-based golden model is compared every cycle)
//  1 Reset: assert rst mid-burst with count=5
//    -> count=0, empty=1, all other flags 0, data_out=0, data_valid=0 immediately (async).
//  2 Fill: write 0x0001..0x0008 back-to-back
//    -> wr_ack=1 x8; almostfull=1 at count=7; full=1 at count=8.
//    -> 9th write gives overflow=1, wr_ack=0, count stays 8.
//  3 Drain: 8 reads -> data_out 0x0001..0x0008 in order, each 1 cycle after rd_en (0 cycles with FWFT);
//    -> almostempty=1 at count=1; empty at 0; 9th read gives underflow=1 and data_out unchanged.
//  4 Simultaneous rd&wr at count=0 / 4 / 8:
//    -> count 0->1 with underflow=1; 4->4 both acked; 8->7 with overflow=1 and correct head word popped.
//  5 Wrap: 20 cycles of interleaved writes/reads keeping count in 3..6
//    -> pointers wrap at 7->0; output order matches the model exactly.
//  6 Non-default params (FIFO_DEPTH=5, AF_LEVEL=3, AE_LEVEL=2):
//    -> almostfull at counts 3-4, almostempty at 1-2, full at 5; wrap at index 4->0.

Source files
------------

// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------------------------
// sync_fifo_param
//
// Parametrised single-clock FIFO. It has a generic word width and depth, programmable
// almost-full and almost-empty levels, an occupancy count and a data_valid strobe. It sits
// between a producer and a consumer that share one clock domain.
//
// Optional build macro:
//   FIFO_FWFT_EN  defined   : first-word-fall-through. data_out shows the head word
//                             combinationally, data_valid = !empty, and rd_en pops the head.
//                 undefined : registered read. An accepted read loads data_out on the next
//                             edge and pulses data_valid for one cycle.
//
// Parameters:
//   FIFO_WIDTH  data word width (>= 1)
//   FIFO_DEPTH  number of entries (>= 2). It does not have to be a power of two.
//   AF_LEVEL    almostfull asserts when AF_LEVEL <= count < FIFO_DEPTH
//   AE_LEVEL    almostempty asserts when 0 < count <= AE_LEVEL
//   CNT_W       width of count, derived as $clog2(FIFO_DEPTH+1)
//
// Ports:
//   clk          in   1           clock, rising edge
//   rst          in   1           asynchronous reset, active high
//   wr_en        in   1           write request
//   data_in      in   FIFO_WIDTH  write data
//   rd_en        in   1           read request (pop acknowledge in FWFT mode)
//   data_out     out  FIFO_WIDTH  read data
//   data_valid   out  1           data_out carries a newly popped word (head valid in FWFT)
//   wr_ack       out  1           registered: write of the previous cycle was accepted
//   overflow     out  1           registered: write of the previous cycle was rejected (full)
//   underflow    out  1           registered: read of the previous cycle was rejected (empty)
//   full         out  1           count == FIFO_DEPTH
//   empty        out  1           count == 0
//   almostfull   out  1           AF_LEVEL <= count < FIFO_DEPTH
//   almostempty  out  1           0 < count <= AE_LEVEL
//   count        out  CNT_W       current occupancy
// ---------------------------------------------------------------------------------------------

module sync_fifo_param #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int unsigned AE_LEVEL   = 1,
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CNT_W-1:0]      count
);

    // Depth is at least 2, so the pointer is at least one bit wide.
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

    // Storage and state
    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             wr_ack_q,    wr_ack_d;
    logic             overflow_q,  overflow_d;
    logic             underflow_q, underflow_d;

    logic wr_accept;
    logic rd_accept;

    // The pointers wrap explicitly at FIFO_DEPTH-1. This keeps depths that are not a power
    // of two working correctly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    // Acceptance is judged against the registered count. A full FIFO therefore rejects the
    // write half of a simultaneous request, and an empty FIFO rejects the read half.
    always_comb begin
        wr_accept = wr_en && (count_q < DEPTH_CNT);
        rd_accept = rd_en && (count_q != '0);
    end

    // Next-state logic for pointers, occupancy and the handshake strobes
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        wr_ack_d    = wr_accept;
        overflow_d  = wr_en && !wr_accept;
        underflow_d = rd_en && !rd_accept;

        if (wr_accept) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (rd_accept) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage has no reset. Its contents do not matter after reset because the pointers
    // and the count restart from zero.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

`ifdef FIFO_FWFT_EN
    // The head word falls through combinationally. It is not meaningful while empty.
    always_comb begin
        data_out   = mem[rd_ptr_q];
        data_valid = !empty;
    end
`else
    logic [FIFO_WIDTH-1:0] data_out_q;
    logic                  data_valid_q;

    // Registered read. data_out keeps the last popped word until the next accepted read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            data_valid_q <= rd_accept;
            if (rd_accept) begin
                data_out_q <= mem[rd_ptr_q];
            end
        end
    end

    always_comb begin
        data_out   = data_out_q;
        data_valid = data_valid_q;
    end
`endif

    // Flags are decoded from count, so they are valid in the same cycle that count updates.
    always_comb begin
        count       = count_q;
        wr_ack      = wr_ack_q;
        overflow    = overflow_q;
        underflow   = underflow_q;
        full        = (count_q == DEPTH_CNT);
        empty       = (count_q == '0);
        almostfull  = (count_q >= AF_CNT) && !full;
        almostempty = (count_q <= AE_CNT) && !empty;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Default instance: 16 bits x 8 entries
    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [15:0] data_in = '0, data_out;
    logic        data_valid, wr_ack, overflow, underflow;
    logic        full, empty, almostfull, almostempty;
    logic [3:0]  count;

    // Small instance: 16 bits x 5 entries, AF=3, AE=2
    logic        wr_en5 = 1'b0, rd_en5 = 1'b0;
    logic [15:0] data_in5 = '0, data_out5;
    logic        data_valid5, wr_ack5, overflow5, underflow5;
    logic        full5, empty5, almostfull5, almostempty5;
    logic [2:0]  count5;

    int total = 0;
    int bad   = 0;
    logic [15:0] model_q [$];
    logic [15:0] exp_word;

    always #5 clk = ~clk;

    sync_fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(data_out), .data_valid(data_valid), .wr_ack(wr_ack), .overflow(overflow),
        .underflow(underflow), .full(full), .empty(empty), .almostfull(almostfull),
        .almostempty(almostempty), .count(count)
    );

    sync_fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(2)) dut5 (
        .clk(clk), .rst(rst), .wr_en(wr_en5), .data_in(data_in5), .rd_en(rd_en5),
        .data_out(data_out5), .data_valid(data_valid5), .wr_ack(wr_ack5),
        .overflow(overflow5), .underflow(underflow5), .full(full5), .empty(empty5),
        .almostfull(almostfull5), .almostempty(almostempty5), .count(count5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one request to the 8-deep FIFO, then sample 1 time unit after the edge.
    task automatic cyc(input logic w, input logic [15:0] d, input logic r);
        wr_en = w; data_in = d; rd_en = r;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic cyc5(input logic w, input logic [15:0] d, input logic r);
        wr_en5 = w; data_in5 = d; rd_en5 = r;
        @(posedge clk); #1;
        wr_en5 = 1'b0; rd_en5 = 1'b0;
    endtask

    initial begin
        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk("por_count", 32'(count), 0);
        chk("por_empty", 32'(empty), 1);
        chk("por_flags", {full, almostfull, almostempty, wr_ack, overflow, underflow}, 0);
        chk("por_dvalid", 32'(data_valid), 0);
        chk("por_dout", 32'(data_out), 0);
        rst = 1'b0;

        // 1: asynchronous reset in the middle of a burst with count = 5
        for (int i = 0; i < 5; i++) cyc(1'b1, 16'h00A0 + 16'(i), 1'b0);
        cyc(1'b0, '0, 1'b1);                     // pop A0 -> count 4
        chk("rst_pre_dout", 32'(data_out), 32'h00A0);
        cyc(1'b1, 16'h00A5, 1'b0);               // count 5
        chk("rst_pre_count", 32'(count), 5);
        wr_en = 1'b1; rd_en = 1'b1; data_in = 16'h00A6;
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_flags", {full, almostfull, almostempty, wr_ack, overflow, underflow}, 0);
        chk("arst_dout", 32'(data_out), 0);
        chk("arst_dvalid", 32'(data_valid), 0);
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
        rst = 1'b0;
        chk("arst_hold_count", 32'(count), 0);

        // 2: fill with 1..8, then one write too many
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 16'(i), 1'b0);
            chk("fill_ack", 32'(wr_ack), 1);
            chk("fill_count", 32'(count), 32'(i));
            chk("fill_af", 32'(almostfull), 32'(i == 7));
            chk("fill_ae", 32'(almostempty), 32'(i == 1));
            chk("fill_full", 32'(full), 32'(i == 8));
        end
        cyc(1'b1, 16'h0009, 1'b0);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_ack", 32'(wr_ack), 0);
        chk("ovf_count", 32'(count), 8);

        // 3: drain in order, then one read too many
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, '0, 1'b1);
            chk("drain_dout", 32'(data_out), 32'(i));
            chk("drain_dvalid", 32'(data_valid), 1);
            chk("drain_count", 32'(count), 32'(8 - i));
            chk("drain_ae", 32'(almostempty), 32'(i == 7));
            chk("drain_empty", 32'(empty), 32'(i == 8));
            chk("drain_ovf", 32'(overflow), 0);
        end
        cyc(1'b0, '0, 1'b1);
        chk("udf_flag", 32'(underflow), 1);
        chk("udf_dout", 32'(data_out), 32'h0008);
        chk("udf_dvalid", 32'(data_valid), 0);
        chk("udf_count", 32'(count), 0);

        // 4: simultaneous read and write at counts 0, 4 and 8
        cyc(1'b1, 16'h0055, 1'b1);
        chk("rw0_count", 32'(count), 1);
        chk("rw0_udf", 32'(underflow), 1);
        chk("rw0_ack", 32'(wr_ack), 1);
        chk("rw0_dvalid", 32'(data_valid), 0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'h0056 + 16'(i), 1'b0);
        chk("rw4_pre", 32'(count), 4);
        cyc(1'b1, 16'h0059, 1'b1);
        chk("rw4_count", 32'(count), 4);
        chk("rw4_ack", 32'(wr_ack), 1);
        chk("rw4_udf", 32'(underflow), 0);
        chk("rw4_dout", 32'(data_out), 32'h0055);
        chk("rw4_dvalid", 32'(data_valid), 1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 16'h005A + 16'(i), 1'b0);
        chk("rw8_pre", 32'(count), 8);
        cyc(1'b1, 16'h005E, 1'b1);
        chk("rw8_count", 32'(count), 7);
        chk("rw8_ovf", 32'(overflow), 1);
        chk("rw8_ack", 32'(wr_ack), 0);
        chk("rw8_dout", 32'(data_out), 32'h0056);

        // 5: interleaved traffic that wraps both pointers, checked against a queue model
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);
        chk("wrap_pre_dout", 32'(data_out), 32'h0059);
        chk("wrap_pre_count", 32'(count), 4);
        model_q = '{16'h005A, 16'h005B, 16'h005C, 16'h005D};
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) begin
                cyc(1'b1, 16'h0100 + 16'(i), 1'b0);
                model_q.push_back(16'h0100 + 16'(i));
            end else begin
                cyc(1'b0, '0, 1'b1);
                exp_word = model_q.pop_front();
                chk("wrap_dout", 32'(data_out), 32'(exp_word));
            end
            chk("wrap_count", 32'(count), 32'(model_q.size()));
        end
        while (model_q.size() > 0) begin
            cyc(1'b0, '0, 1'b1);
            exp_word = model_q.pop_front();
            chk("wrap_tail", 32'(data_out), 32'(exp_word));
        end
        chk("wrap_empty", 32'(empty), 1);

        // 6: depth 5, AF=3, AE=2
        chk("d5_empty", 32'(empty5), 1);
        for (int i = 1; i <= 5; i++) begin
            cyc5(1'b1, 16'h0200 + 16'(i), 1'b0);
            chk("d5_count", 32'(count5), 32'(i));
            chk("d5_ae", 32'(almostempty5), 32'(i <= 2));
            chk("d5_af", 32'(almostfull5), 32'(i == 3 || i == 4));
            chk("d5_full", 32'(full5), 32'(i == 5));
        end
        cyc5(1'b1, 16'h02FF, 1'b0);
        chk("d5_ovf", 32'(overflow5), 1);
        for (int i = 1; i <= 5; i++) begin
            cyc5(1'b0, '0, 1'b1);
            chk("d5_dout", 32'(data_out5), 32'h0200 + 32'(i));
        end
        // Both pointers are back at index 0 after five operations each.
        cyc5(1'b1, 16'h0301, 1'b0);
        cyc5(1'b1, 16'h0302, 1'b0);
        cyc5(1'b0, '0, 1'b1);
        chk("d5_wrap0", 32'(data_out5), 32'h0301);
        cyc5(1'b0, '0, 1'b1);
        chk("d5_wrap1", 32'(data_out5), 32'h0302);
        chk("d5_end_empty", 32'(empty5), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
